// File: rtl/ssd_scan_decoder.sv
// Seven-segment scan receiver: stability-qualifies sampled segment/digit-enable patterns,
// decodes them to digit codes and hands out complete frames. Hex A..F decode: `SSD_DEC_HEX_EN.
module ssd_scan_decoder #(
    parameter int unsigned NDIGITS    = 4,
    parameter int unsigned STABLE_CYC = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a,
    input  logic                   b,
    input  logic                   c,
    input  logic                   d,
    input  logic                   e,
    input  logic                   f,
    input  logic                   g,
    input  logic [NDIGITS-1:0]     dig_en,
    output logic [4*NDIGITS-1:0]   frame_digits,
    output logic [NDIGITS-1:0]     frame_blank,
    output logic [NDIGITS-1:0]     frame_err,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic                   sel_err,
    output logic                   overflow
);

    localparam int unsigned SAMP_W = 7 + NDIGITS;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [SAMP_W-1:0]    samp_q, samp_d, prev_q, prev_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NDIGITS-1:0]   seen_q, seen_d;
    logic [4*NDIGITS-1:0] work_code_q, work_code_d;
    logic [NDIGITS-1:0]   work_blank_q, work_blank_d;
    logic [NDIGITS-1:0]   work_err_q, work_err_d;
    logic [4*NDIGITS-1:0] frame_digits_q, frame_digits_d;
    logic [NDIGITS-1:0]   frame_blank_q, frame_blank_d;
    logic [NDIGITS-1:0]   frame_err_q, frame_err_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 sel_err_q, sel_err_d;
    logic                 overflow_q, overflow_d;

    logic                 match;
    logic                 commit;
    logic                 complete;
    logic [6:0]           seg;
    logic [NDIGITS-1:0]   sel;
    logic [NDIGITS-1:0]   seen_all;
    logic [3:0]           dec_code;
    logic                 dec_blank;
    logic                 dec_err;

    assign seg = samp_q[SAMP_W-1 -: 7];
    assign sel = samp_q[NDIGITS-1:0];

    // Two-stage sampling and stability counter; commit fires once per stable run.
    always_comb begin
        samp_d = {a, b, c, d, e, f, g, dig_en};
        prev_d = samp_q;
        match  = (samp_q == prev_q);
        cnt_d  = '0;
        if (match) begin
            cnt_d = (cnt_q == CNT_W'(STABLE_CYC)) ? cnt_q : cnt_q + CNT_W'(1);
        end
        commit = match && (cnt_q == CNT_W'(STABLE_CYC - 1));
    end

    // Segment pattern {a..g} to digit code.
    always_comb begin
        dec_code  = 4'd0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg)
            7'b1111110: dec_code = 4'd0;
            7'b0110000: dec_code = 4'd1;
            7'b1101101: dec_code = 4'd2;
            7'b1111001: dec_code = 4'd3;
            7'b0110011: dec_code = 4'd4;
            7'b1011011: dec_code = 4'd5;
            7'b1011111: dec_code = 4'd6;
            7'b1110000: dec_code = 4'd7;
            7'b1111111: dec_code = 4'd8;
            7'b1111011: dec_code = 4'd9;
            7'b0000000: dec_blank = 1'b1;
`ifdef SSD_DEC_HEX_EN
            7'b1110111: dec_code = 4'd10;
            7'b0011111: dec_code = 4'd11;
            7'b1001110: dec_code = 4'd12;
            7'b0111101: dec_code = 4'd13;
            7'b1001111: dec_code = 4'd14;
            7'b1000111: dec_code = 4'd15;
`endif
            default:    dec_err = 1'b1;
        endcase
    end

    // Working frame assembly; a bad digit select on commit only raises the sticky flag.
    always_comb begin
        work_code_d  = work_code_q;
        work_blank_d = work_blank_q;
        work_err_d   = work_err_q;
        seen_d       = seen_q;
        sel_err_d    = sel_err_q;
        complete     = 1'b0;
        seen_all     = seen_q | sel;
        if (commit) begin
            if ($onehot(sel)) begin
                for (int unsigned i = 0; i < NDIGITS; i++) begin
                    if (sel[i]) begin
                        work_code_d[4*i +: 4] = dec_code;
                        work_blank_d[i]       = dec_blank;
                        work_err_d[i]         = dec_err;
                    end
                end
                if (&seen_all) begin
                    complete = 1'b1;
                    seen_d   = '0;
                end else begin
                    seen_d = seen_all;
                end
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    // Output frame FSM; the loaded frame includes the completing write.
    always_comb begin
        state_d        = state_q;
        frame_digits_d = frame_digits_q;
        frame_blank_d  = frame_blank_q;
        frame_err_d    = frame_err_q;
        overflow_d     = overflow_q;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    frame_digits_d = work_code_d;
                    frame_blank_d  = work_blank_d;
                    frame_err_d    = work_err_d;
                    state_d        = FULL;
                end
            end
            FULL: begin
                if (complete && frame_ready) begin
                    frame_digits_d = work_code_d;
                    frame_blank_d  = work_blank_d;
                    frame_err_d    = work_err_d;
                end else if (complete) begin
                    overflow_d = 1'b1;
                end else if (frame_ready) begin
                    state_d = EMPTY;
                end
            end
        endcase
        frame_valid_d = (state_d == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= EMPTY;
            samp_q         <= '0;
            prev_q         <= '0;
            cnt_q          <= '0;
            seen_q         <= '0;
            work_code_q    <= '0;
            work_blank_q   <= '0;
            work_err_q     <= '0;
            frame_digits_q <= '0;
            frame_blank_q  <= '0;
            frame_err_q    <= '0;
            frame_valid_q  <= 1'b0;
            sel_err_q      <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            samp_q         <= samp_d;
            prev_q         <= prev_d;
            cnt_q          <= cnt_d;
            seen_q         <= seen_d;
            work_code_q    <= work_code_d;
            work_blank_q   <= work_blank_d;
            work_err_q     <= work_err_d;
            frame_digits_q <= frame_digits_d;
            frame_blank_q  <= frame_blank_d;
            frame_err_q    <= frame_err_d;
            frame_valid_q  <= frame_valid_d;
            sel_err_q      <= sel_err_d;
            overflow_q     <= overflow_d;
        end
    end

    assign frame_digits = frame_digits_q;
    assign frame_blank  = frame_blank_q;
    assign frame_err    = frame_err_q;
    assign frame_valid  = frame_valid_q;
    assign sel_err      = sel_err_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed scenarios plus random scans, every cycle compared
// against a run-length based reference model of the receive path.
module tb_ssd_scan_decoder;

    localparam int unsigned NDIGITS    = 4;
    localparam int unsigned STABLE_CYC = 8;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 a, b, c, d, e, f, g;
    logic [NDIGITS-1:0]   dig_en;
    logic                 frame_ready;
    logic [4*NDIGITS-1:0] frame_digits;
    logic [NDIGITS-1:0]   frame_blank;
    logic [NDIGITS-1:0]   frame_err;
    logic                 frame_valid;
    logic                 sel_err;
    logic                 overflow;

    ssd_scan_decoder #(.NDIGITS(NDIGITS), .STABLE_CYC(STABLE_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .dig_en(dig_en),
        .frame_digits(frame_digits), .frame_blank(frame_blank), .frame_err(frame_err),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .sel_err(sel_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [6+NDIGITS:0]   m_last;
    int unsigned          m_run;
    logic                 m_pend;
    logic [6:0]           m_pseg;
    logic [NDIGITS-1:0]   m_pdig;
    logic [4*NDIGITS-1:0] m_work;
    logic [NDIGITS-1:0]   m_wblank, m_werr, m_seen;
    logic [4*NDIGITS-1:0] f_digits;
    logic [NDIGITS-1:0]   f_blank, f_err;
    logic                 f_valid, m_selerr, m_ovf;

    int unsigned          nvalid;
    logic [4*NDIGITS-1:0] cap_digits;
    logic [NDIGITS-1:0]   cap_blank, cap_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_decode(input logic [6:0] p, output logic [3:0] code,
                                     output logic bl, output logic er);
        int top;
        logic found;
        code  = 4'd0;
        found = 1'b0;
        bl    = (p == 7'h00);
`ifdef SSD_DEC_HEX_EN
        top = 15;
`else
        top = 9;
`endif
        for (int k = 0; k <= top; k++) begin
            if (SEG_TAB[k] == p) begin
                code  = 4'(k);
                found = 1'b1;
            end
        end
        er = !found && !bl;
    endfunction

    task automatic m_init();
        m_last   = '0;
        m_run    = 2;
        m_pend   = 1'b0;
        m_pseg   = '0;
        m_pdig   = '0;
        m_work   = '0;
        m_wblank = '0;
        m_werr   = '0;
        m_seen   = '0;
        f_digits = '0;
        f_blank  = '0;
        f_err    = '0;
        f_valid  = 1'b0;
        m_selerr = 1'b0;
        m_ovf    = 1'b0;
    endtask

    // One clock edge of the reference: a pattern seen on STABLE_CYC+1 consecutive edges
    // is written into the working frame on the following edge.
    task automatic m_edge(input logic [6:0] s, input logic [NDIGITS-1:0] dg, input logic r);
        logic               cm, complete, bl, er;
        logic [6:0]         cs;
        logic [NDIGITS-1:0] cd;
        logic [3:0]         code;
        int                 hot, pos;
        cm = m_pend;
        cs = m_pseg;
        cd = m_pdig;
        if ({s, dg} == m_last) m_run++;
        else begin
            m_run  = 1;
            m_last = {s, dg};
        end
        m_pend   = (m_run == STABLE_CYC + 1);
        m_pseg   = s;
        m_pdig   = dg;
        complete = 1'b0;
        if (cm) begin
            hot = 0;
            pos = 0;
            for (int i = 0; i < int'(NDIGITS); i++) begin
                if (cd[i]) begin
                    hot++;
                    pos = i;
                end
            end
            if (hot == 1) begin
                m_decode(cs, code, bl, er);
                m_work[4*pos +: 4] = code;
                m_wblank[pos]      = bl;
                m_werr[pos]        = er;
                m_seen[pos]        = 1'b1;
                if (m_seen == '1) begin
                    complete = 1'b1;
                    m_seen   = '0;
                end
            end else begin
                m_selerr = 1'b1;
            end
        end
        if (complete && (!f_valid || r)) begin
            f_digits = m_work;
            f_blank  = m_wblank;
            f_err    = m_werr;
            f_valid  = 1'b1;
        end else if (complete) begin
            m_ovf = 1'b1;
        end else if (f_valid && r) begin
            f_valid = 1'b0;
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({frame_valid, sel_err, overflow, frame_blank, frame_err, frame_digits});
    endfunction

    function automatic logic [63:0] mdl_vec();
        return 64'({f_valid, m_selerr, m_ovf, f_blank, f_err, f_digits});
    endfunction

    task automatic step(input logic [6:0] s, input logic [NDIGITS-1:0] dg, input logic r);
        {a, b, c, d, e, f, g} = s;
        dig_en      = dg;
        frame_ready = r;
        @(posedge clk);
        m_edge(s, dg, r);
        #1;
        chk("cycle", dut_vec(), mdl_vec());
        if (frame_valid) begin
            nvalid++;
            cap_digits = frame_digits;
            cap_blank  = frame_blank;
            cap_err    = frame_err;
        end
    endtask

    task automatic hold(input logic [6:0] s, input logic [NDIGITS-1:0] dg, input logic r,
                        input int n);
        repeat (n) step(s, dg, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {a, b, c, d, e, f, g} = 7'h00;
        dig_en      = '0;
        frame_ready = 1'b0;
        m_init();
        #1;
        chk("reset", dut_vec(), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [6:0]         r_seg;
    logic [NDIGITS-1:0] r_dig;
    int                 r_sel, r_len;

    initial begin
        {a, b, c, d, e, f, g} = 7'h00;
        dig_en      = '0;
        frame_ready = 1'b0;
        nvalid      = 0;
        cap_digits  = '0;
        cap_blank   = '0;
        cap_err     = '0;

        // Basic scan 1,2,3,4 with consumer always ready
        do_reset();
        nvalid = 0;
        hold(SEG_TAB[1], 4'b0001, 1'b1, 10);
        hold(SEG_TAB[2], 4'b0010, 1'b1, 10);
        hold(SEG_TAB[3], 4'b0100, 1'b1, 10);
        hold(SEG_TAB[4], 4'b1000, 1'b1, 10);
        hold(SEG_TAB[8], 4'b0001, 1'b1, 4);
        chk("t1_pulses", 64'(nvalid), 64'd1);
        chk("t1_digits", 64'(cap_digits), 64'h4321);
        chk("t1_blank_err", 64'({cap_blank, cap_err}), 64'd0);

        // Stability boundary: 7 cycles too short, 9 cycles commits
        do_reset();
        hold(SEG_TAB[1], 4'b0001, 1'b0, 12);
        hold(SEG_TAB[2], 4'b0010, 1'b0, 12);
        hold(SEG_TAB[4], 4'b0100, 1'b0, 12);
        hold(SEG_TAB[3], 4'b1000, 1'b0, 7);
        hold(SEG_TAB[0], 4'b0001, 1'b0, 5);
        chk("t2_short_nocommit", 64'(frame_valid), 64'd0);
        hold(SEG_TAB[3], 4'b1000, 1'b0, 9);
        hold(SEG_TAB[8], 4'b0001, 1'b0, 3);
        chk("t2_valid", 64'(frame_valid), 64'd1);
        chk("t2_digits", 64'(frame_digits), 64'h3421);

        // Blank, undecodable and hex patterns
        do_reset();
        hold(SEG_TAB[7], 4'b0001, 1'b0, 12);
        hold(7'b0000000, 4'b0100, 1'b0, 12);
        hold(7'b1010101, 4'b0010, 1'b0, 12);
        hold(7'b1110111, 4'b1000, 1'b0, 12);
        hold(SEG_TAB[8], 4'b0001, 1'b0, 3);
        chk("t3_blank", 64'(frame_blank), 64'b0100);
`ifdef SSD_DEC_HEX_EN
        chk("t3_err", 64'(frame_err), 64'b0010);
        chk("t3_digits", 64'(frame_digits), 64'hA007);
`else
        chk("t3_err", 64'(frame_err), 64'b1010);
        chk("t3_digits", 64'(frame_digits), 64'h0007);
`endif

        // Overflow while held, then ready coinciding with completion
        hold(SEG_TAB[1], 4'b0001, 1'b0, 12);
        hold(SEG_TAB[2], 4'b0010, 1'b0, 12);
        hold(SEG_TAB[3], 4'b0100, 1'b0, 12);
        hold(SEG_TAB[4], 4'b1000, 1'b0, 12);
        chk("t4_overflow", 64'(overflow), 64'd1);
`ifdef SSD_DEC_HEX_EN
        chk("t4_held", 64'(frame_digits), 64'hA007);
`else
        chk("t4_held", 64'(frame_digits), 64'h0007);
`endif
        hold(SEG_TAB[5], 4'b0001, 1'b0, 12);
        hold(SEG_TAB[6], 4'b0010, 1'b0, 12);
        hold(SEG_TAB[7], 4'b0100, 1'b0, 12);
        hold(SEG_TAB[9], 4'b1000, 1'b0, 9);
        step(SEG_TAB[8], 4'b0001, 1'b1);
        chk("t4_reload_valid", 64'(frame_valid), 64'd1);
        hold(SEG_TAB[8], 4'b0001, 1'b0, 2);
        chk("t4_reload_digits", 64'(frame_digits), 64'h9765);

        // Bad digit select, then reset in the middle of a scan
        do_reset();
        hold(SEG_TAB[1], 4'b0110, 1'b1, 12);
        chk("t5_sel_err", 64'(sel_err), 64'd1);
        hold(SEG_TAB[1], 4'b0001, 1'b1, 12);
        hold(SEG_TAB[2], 4'b0010, 1'b1, 12);
        hold(SEG_TAB[3], 4'b0100, 1'b1, 5);
        do_reset();
        hold(SEG_TAB[1], 4'b0001, 1'b0, 12);
        hold(SEG_TAB[2], 4'b0010, 1'b0, 12);
        hold(SEG_TAB[3], 4'b0100, 1'b0, 12);
        hold(SEG_TAB[4], 4'b1000, 1'b0, 12);
        hold(SEG_TAB[8], 4'b0001, 1'b0, 3);
        chk("t5_clean_valid", 64'(frame_valid), 64'd1);
        chk("t5_clean_digits", 64'(frame_digits), 64'h4321);
        chk("t5_clean_flags", 64'({sel_err, overflow, frame_blank, frame_err}), 64'd0);

        // Random scans with random consumer back-pressure
        do_reset();
        for (int h = 0; h < 300; h++) begin
            r_sel = int'($urandom_range(0, 9));
            if (r_sel < 6)      r_seg = SEG_TAB[$urandom_range(0, 15)];
            else if (r_sel < 8) r_seg = 7'h00;
            else                r_seg = 7'($urandom);
            if ($urandom_range(0, 9) == 0) r_dig = NDIGITS'($urandom);
            else                           r_dig = NDIGITS'(1 << $urandom_range(0, NDIGITS - 1));
            r_len = int'($urandom_range(1, STABLE_CYC + 6));
            repeat (r_len) step(r_seg, r_dig, 1'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
